// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl
//   Scan controller for the 12-key launchpad keypad. Drives the 12:1 key-line
//   mux select, samples the mux output once per select dwell, debounces whole
//   scan frames and reports one key code with a single-cycle valid per press.
//
// Ports:
//   clk       system clock, rising edge
//   rst_n     synchronous active-low reset
//   scan_en   1 = scanning advances, 0 = scan and debounce state frozen
//   D_out     selected key line from the mux, 1 = pressed
//   B_in      mux select, 0-9 = D0-D9, 10 = D_sharp, 11 = D_star
//   key_code  last accepted key code (0-11)
//   key_valid one-cycle pulse when a new press is accepted
//   key_held  level, high while the accepted key is considered held
module keypad_scan_ctrl #(
    parameter int unsigned DWELL    = 4,
    parameter int unsigned DEBOUNCE = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scan_en,
    input  logic       D_out,
    output logic [3:0] B_in,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int unsigned DW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int unsigned CW = $clog2(DEBOUNCE + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
    localparam logic [CW-1:0] CNT_DONE   = CW'(DEBOUNCE);
    localparam logic [3:0]    LAST_KEY   = 4'd11;

    typedef enum logic [1:0] {
        IDLE,
        CAND,
        HELD,
        REL
    } state_t;

    state_t        state;
    logic [DW-1:0] dwell;
    logic          any_pressed;
    logic [3:0]    first_code;
    logic [3:0]    cand;
    logic [CW-1:0] cnt;

    // Completed-frame view at the frame-end edge: the index-11 sample is
    // folded in here because the accumulator has not yet registered it.
    logic          frm_any;
    logic [3:0]    frm_code;
    logic [CW-1:0] cnt_next;
    logic          cnt_hit;

    always_comb begin
        frm_any  = any_pressed | D_out;
        frm_code = any_pressed ? first_code : B_in;
        cnt_next = cnt + CW'(1);
        cnt_hit  = (cnt_next == CNT_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            dwell       <= '0;
            B_in        <= '0;
            any_pressed <= 1'b0;
            first_code  <= '0;
            cand        <= '0;
            cnt         <= '0;
            key_code    <= '0;
            key_valid   <= 1'b0;
            key_held    <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            if (scan_en) begin
                if (dwell == DWELL_LAST) begin
                    dwell <= '0;
                    if (B_in == LAST_KEY) begin
                        B_in        <= '0;
                        any_pressed <= 1'b0;
                        first_code  <= '0;
                        case (state)
                            IDLE: begin
                                if (frm_any) begin
                                    cand <= frm_code;
                                    cnt  <= CW'(1);
                                    if (DEBOUNCE == 1) begin
                                        key_code  <= frm_code;
                                        key_valid <= 1'b1;
                                        key_held  <= 1'b1;
                                        state     <= HELD;
                                    end else begin
                                        state <= CAND;
                                    end
                                end
                            end
                            CAND: begin
                                if (!frm_any) begin
                                    cnt   <= '0;
                                    state <= IDLE;
                                end else if (frm_code == cand) begin
                                    cnt <= cnt_next;
                                    if (cnt_hit) begin
                                        key_code  <= cand;
                                        key_valid <= 1'b1;
                                        key_held  <= 1'b1;
                                        state     <= HELD;
                                    end
                                end else begin
                                    cand <= frm_code;
                                    cnt  <= CW'(1);
                                end
                            end
                            HELD: begin
                                if (!frm_any) begin
                                    cnt <= CW'(1);
                                    // A single empty frame already satisfies a
                                    // one-frame release.
                                    if (DEBOUNCE == 1) begin
                                        key_held <= 1'b0;
                                        state    <= IDLE;
                                    end else begin
                                        state <= REL;
                                    end
                                end
                            end
                            REL: begin
                                if (frm_any) begin
                                    state <= HELD;
                                end else if (cnt_hit) begin
                                    cnt      <= '0;
                                    key_held <= 1'b0;
                                    state    <= IDLE;
                                end else begin
                                    cnt <= cnt_next;
                                end
                            end
                            default: state <= IDLE;
                        endcase
                    end else begin
                        B_in <= B_in + 4'd1;
                        if (D_out && !any_pressed) begin
                            any_pressed <= 1'b1;
                            first_code  <= B_in;
                        end
                    end
                end else begin
                    dwell <= dwell + DW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
module tb_keypad_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        scan_en;
    logic        D_out;
    logic [3:0]  B_in;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic [11:0] keys;

    int checks   = 0;
    int failures = 0;
    int vcount   = 0;

    always #5 clk = ~clk;

    // Behavioural 12:1 key-line mux
    assign D_out = (B_in < 4'd12) ? keys[B_in] : 1'b0;

    keypad_scan_ctrl #(.DWELL(4), .DEBOUNCE(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .scan_en   (scan_en),
        .D_out     (D_out),
        .B_in      (B_in),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock; outputs sampled 1 time unit after the rising edge.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (key_valid === 1'b1) vcount++;
        end
    endtask

    // Advance until just after the 11 -> 0 select wrap (first cycle of a frame).
    task automatic sync_frame();
        logic [3:0] prev;
        logic       found;
        found = 1'b0;
        prev  = B_in;
        for (int i = 0; i < 200 && !found; i++) begin
            tick(1);
            if (prev == 4'd11 && B_in == 4'd0) found = 1'b1;
            prev = B_in;
        end
        check("sync_frame_found", 32'(found), 32'd1);
    endtask

    initial begin
        rst_n   = 1'b0;
        scan_en = 1'b1;
        keys    = '0;
        tick(3);
        check("por_b_in", 32'(B_in), 32'd0);
        check("por_key_code", 32'(key_code), 32'd0);
        check("por_key_valid", 32'(key_valid), 32'd0);
        check("por_key_held", 32'(key_held), 32'd0);

        // Reset mid-scan
        rst_n = 1'b1;
        tick(13);
        rst_n = 1'b0;
        tick(2);
        check("rst_b_in", 32'(B_in), 32'd0);
        check("rst_key_code", 32'(key_code), 32'd0);
        check("rst_key_valid", 32'(key_valid), 32'd0);
        check("rst_key_held", 32'(key_held), 32'd0);

        // Select sequence after reset: 4 cycles per value, wraps 11 -> 0
        rst_n = 1'b1;
        for (int k = 1; k <= 52; k++) begin
            tick(1);
            check("scan_b_in", 32'(B_in), 32'((k / 4) % 12));
        end

        // Clean press of D5
        sync_frame();
        keys[5] = 1'b1;
        vcount  = 0;
        tick(143);
        check("press_no_early_valid", 32'(vcount), 32'd0);
        check("press_not_held_early", 32'(key_held), 32'd0);
        tick(1);
        check("press_valid_at_144", 32'(key_valid), 32'd1);
        check("press_code", 32'(key_code), 32'd5);
        check("press_held", 32'(key_held), 32'd1);
        tick(48);
        check("press_single_pulse", 32'(vcount), 32'd1);
        check("press_still_held", 32'(key_held), 32'd1);

        // Release with re-bounce: 2 empty, 1 pressed, 3 empty
        keys = '0;
        tick(96);
        keys[5] = 1'b1;
        tick(48);
        keys = '0;
        tick(143);
        check("rel_held_before", 32'(key_held), 32'd1);
        tick(1);
        check("rel_held_fall", 32'(key_held), 32'd0);
        check("rel_no_second_valid", 32'(vcount), 32'd1);
        check("rel_code_kept", 32'(key_code), 32'd5);

        // Bounce: 1,0,1,0 frames
        vcount = 0;
        keys[5] = 1'b1;
        tick(48);
        keys = '0;
        tick(48);
        keys[5] = 1'b1;
        tick(48);
        keys = '0;
        tick(144);
        check("bounce_no_valid", 32'(vcount), 32'd0);
        check("bounce_not_held", 32'(key_held), 32'd0);
        check("bounce_code_kept", 32'(key_code), 32'd5);

        // Priority: D3 and D_star together -> lowest index wins
        keys[3]  = 1'b1;
        keys[11] = 1'b1;
        tick(144);
        check("prio_valid", 32'(key_valid), 32'd1);
        check("prio_code", 32'(key_code), 32'd3);
        keys = '0;
        tick(144);
        check("prio_released", 32'(key_held), 32'd0);

        // Boundary: D_star alone, sampled on the frame-end edge itself
        vcount   = 0;
        keys[11] = 1'b1;
        tick(144);
        check("star_valid", 32'(key_valid), 32'd1);
        check("star_code", 32'(key_code), 32'd11);
        check("star_single_pulse", 32'(vcount), 32'd1);
        keys = '0;
        tick(144);
        check("star_released", 32'(key_held), 32'd0);

        // Freeze mid-frame: select=1 with dwell=2 for 10 cycles, key 1 pressed
        // only while frozen so a stray sample would seed a candidate.
        vcount = 0;
        tick(6);
        check("frz_b_in_before", 32'(B_in), 32'd1);
        scan_en = 1'b0;
        keys[1] = 1'b1;
        tick(10);
        check("frz_b_in_held", 32'(B_in), 32'd1);
        keys[1] = 1'b0;
        scan_en = 1'b1;
        tick(1);
        check("frz_resume_dwell3", 32'(B_in), 32'd1);
        tick(1);
        check("frz_resume_advance", 32'(B_in), 32'd2);
        tick(40);
        check("frz_frame_start", 32'(B_in), 32'd0);
        keys[1] = 1'b1;
        tick(96);
        check("frz_no_sample_taken", 32'(vcount), 32'd0);
        check("frz_not_held", 32'(key_held), 32'd0);
        keys = '0;
        tick(48);

        // Reset while in CAND with cnt=2: debounce restarts from scratch
        keys[7] = 1'b1;
        tick(96);
        tick(5);
        rst_n = 1'b0;
        tick(2);
        check("cand_rst_code", 32'(key_code), 32'd0);
        check("cand_rst_b_in", 32'(B_in), 32'd0);
        rst_n  = 1'b1;
        vcount = 0;
        tick(143);
        check("cand_rst_no_early_valid", 32'(vcount), 32'd0);
        tick(1);
        check("cand_rst_valid", 32'(key_valid), 32'd1);
        check("cand_rst_new_code", 32'(key_code), 32'd7);
        keys = '0;
        tick(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=completion");
        $fatal(1, "watchdog expired");
    end

endmodule
